mc_ctrl206: RTL

Multi-cycle control sequencer for the single-cycle datapath (DataPath206-style signal bundle). It turns the datapath into a 3–5 state-per-instruction machine. It decodes the fetched instruction once per instruction, then drives the datapath's control bundle state by state. It also generates PC/IR write strobes and halts on undecodable instructions. It sits between the fetch unit's Instruction output and every control input of the datapath.

---
 rtl/mc_ctrl206.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl206.sv
// Multi-cycle control sequencer for the DataPath206 control bundle.
// Decodes the captured instruction once per instruction and walks IF/ID/EX/MEM/WB.
module mc_ctrl206 #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      Instruction,
  output logic             PCWr,
  output logic             IRWr,
  output logic             Branch,
  output logic             Jump,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic             MemToReg,
  output logic             RegWr,
  output logic             MemWr,
  output logic             Rtype,
  output logic             Jal,
  output logic             Rtype_J,
  output logic             Rtype_L,
  output logic             WrByte,
  output logic [4:0]       ALUCtr,
  output logic [1:0]       ExtOp,
  output logic [1:0]       LoadByte,
  output logic [2:0]       state,
  output logic             halt,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StEx   = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StHalt = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    ClsRalu, ClsJr, ClsJalr, ClsIalu, ClsLoad, ClsStore, ClsBranch, ClsJ, ClsJal, ClsIll
  } cls_e;

  localparam logic [4:0] AluAdd   = 5'b00000;
  localparam logic [4:0] AluAddu  = 5'b00001;
  localparam logic [4:0] AluSub   = 5'b00010;
  localparam logic [4:0] AluSubu  = 5'b00011;
  localparam logic [4:0] AluAnd   = 5'b00100;
  localparam logic [4:0] AluOr    = 5'b00101;
  localparam logic [4:0] AluSlt   = 5'b00110;
  localparam logic [4:0] AluSll   = 5'b00111;
  localparam logic [4:0] AluPassB = 5'b01001;
  localparam logic [4:0] AluPassA = 5'b01010;

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       funct_q, funct_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  cls_e       cls;
  logic [4:0] dec_alu;
  logic [1:0] dec_ext;
  logic [1:0] dec_lb;
  logic       dec_alu_src, dec_reg_dst, dec_rtype, dec_mem_to_reg, dec_wr_byte;
  logic       is_last;

  // Decode of the latched op/funct; illegal encodings leave every control at 0.
  always_comb begin
    cls            = ClsIll;
    dec_alu        = 5'b00000;
    dec_ext        = 2'b00;
    dec_lb         = 2'b00;
    dec_alu_src    = 1'b0;
    dec_reg_dst    = 1'b0;
    dec_rtype      = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_wr_byte    = 1'b0;
    case (op_q)
      6'b000000: begin
        cls         = ClsRalu;
        dec_reg_dst = 1'b1;
        dec_rtype   = 1'b1;
        case (funct_q)
          6'b100000: dec_alu = AluAdd;
          6'b100001: dec_alu = AluAddu;
          6'b100010: dec_alu = AluSub;
          6'b100011: dec_alu = AluSubu;
          6'b100100: dec_alu = AluAnd;
          6'b100101: dec_alu = AluOr;
          6'b101010: dec_alu = AluSlt;
          6'b000000: dec_alu = AluSll;
          6'b001000: begin
            cls     = ClsJr;
            dec_alu = AluPassA;
          end
          6'b001001: begin
            cls     = ClsJalr;
            dec_alu = AluPassA;
          end
          default: begin
            cls         = ClsIll;
            dec_reg_dst = 1'b0;
            dec_rtype   = 1'b0;
          end
        endcase
      end
      6'b001000, 6'b001001: begin
        cls         = ClsIalu;
        dec_alu     = op_q[0] ? AluAddu : AluAdd;
        dec_ext     = 2'b01;
        dec_alu_src = 1'b1;
      end
      6'b001100, 6'b001101: begin
        cls         = ClsIalu;
        dec_alu     = op_q[0] ? AluOr : AluAnd;
        dec_alu_src = 1'b1;
      end
      6'b001111: begin
        cls         = ClsIalu;
        dec_alu     = AluPassB;
        dec_ext     = 2'b10;
        dec_alu_src = 1'b1;
      end
      6'b100011, 6'b100000, 6'b100100: begin
        cls            = ClsLoad;
        dec_alu        = AluAddu;
        dec_ext        = 2'b01;
        dec_alu_src    = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_lb         = (op_q == 6'b100000) ? 2'b11 : (op_q == 6'b100100) ? 2'b10 : 2'b00;
      end
      6'b101011, 6'b101000: begin
        cls         = ClsStore;
        dec_alu     = AluAddu;
        dec_ext     = 2'b01;
        dec_alu_src = 1'b1;
        dec_wr_byte = (op_q == 6'b101000);
      end
      6'b000100, 6'b000101: begin
        cls     = ClsBranch;
        dec_alu = AluSubu;
        dec_ext = 2'b01;
      end
      6'b000010: cls = ClsJ;
      6'b000011: cls = ClsJal;
      default:   cls = ClsIll;
    endcase
  end

  always_comb begin
    is_last = 1'b0;
    case (state_q)
      StEx:    is_last = (cls == ClsBranch) || (cls == ClsJ) || (cls == ClsJr);
      StMem:   is_last = (cls == ClsStore);
      StWb:    is_last = 1'b1;
      default: is_last = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    funct_d   = funct_q;
    retired_d = retired_q;
    case (state_q)
      StIf: begin
        if (run) begin
          op_d    = Instruction[31:26];
          funct_d = Instruction[5:0];
          state_d = StId;
        end
      end
      StId:    state_d = (cls == ClsIll) ? StHalt : StEx;
      StEx: begin
        if (is_last)                                    state_d = StIf;
        else if ((cls == ClsLoad) || (cls == ClsStore)) state_d = StMem;
        else                                            state_d = StWb;
      end
      StMem:   state_d = (cls == ClsLoad) ? StWb : StIf;
      StWb:    state_d = StIf;
      StHalt:  state_d = StHalt;
      default: state_d = StIf;
    endcase
    if (is_last) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIf;
      op_q      <= 6'b000000;
      funct_q   <= 6'b000000;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    Branch   = 1'b0;
    Jump     = 1'b0;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    MemToReg = 1'b0;
    RegWr    = 1'b0;
    MemWr    = 1'b0;
    Rtype    = 1'b0;
    Jal      = 1'b0;
    Rtype_J  = 1'b0;
    Rtype_L  = 1'b0;
    WrByte   = 1'b0;
    ALUCtr   = 5'b00000;
    ExtOp    = 2'b00;
    LoadByte = 2'b00;
    if ((state_q == StId) || (state_q == StEx) || (state_q == StMem) || (state_q == StWb)) begin
      ALUCtr   = dec_alu;
      ALUSrc   = dec_alu_src;
      ExtOp    = dec_ext;
      RegDst   = dec_reg_dst;
      Rtype    = dec_rtype;
      MemToReg = dec_mem_to_reg;
      LoadByte = dec_lb;
      WrByte   = dec_wr_byte;
    end
    case (state_q)
      StIf: IRWr = run;
      StEx: begin
        PCWr    = (cls == ClsBranch) || (cls == ClsJ) || (cls == ClsJal) ||
                  (cls == ClsJr) || (cls == ClsJalr);
        Branch  = (cls == ClsBranch);
        Jump    = (cls == ClsJ) || (cls == ClsJal);
        Rtype_J = (cls == ClsJr) || (cls == ClsJalr);
        Jal     = (cls == ClsJal);
        Rtype_L = (cls == ClsJalr);
      end
      StMem: begin
        MemWr = (cls == ClsStore);
        PCWr  = (cls == ClsStore);
      end
      StWb: begin
        RegWr   = 1'b1;
        // jal/jalr already redirected the PC in EX.
        PCWr    = (cls != ClsJal) && (cls != ClsJalr);
        Jal     = (cls == ClsJal);
        Rtype_L = (cls == ClsJalr);
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign halt    = (state_q == StHalt);
  assign retired = retired_q;

endmodule
